// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Pipeline sequencing controller for the five-stage RV32I core. Generates the
//   load enables and bubble (flush) strobes for the F/D, D/X, X/M and M/W stage
//   registers and the PC. It handles three events, highest priority first:
//     1. an outstanding data-memory access in M holds the front of the pipe and
//        bubbles M/W until memack_i arrives (or the wait times out)
//     2. a taken branch/jump resolved in X flushes F/D and D/X
//     3. a load in X feeding a source register of the instruction in D stalls
//        F/D for one cycle and bubbles D/X
//   All outputs are combinational from the state and the current inputs, so a
//   decision takes effect at the same edge as the inputs that cause it. Flush
//   has priority over enable at each stage register.
//
// Parameters
//   TIMEOUT_CYC  cycles (1..255) spent in MEMWAIT without ack before ERR
//
// Ports
//   clk_i, rst_i               clock, async active-high reset
//   rs1addr_D_i, rs2addr_D_i   source registers of the instruction in D
//   rs1use_D_i, rs2use_D_i     D instruction reads rs1 / rs2
//   rdaddr_X_i, rdwr_X_i       destination / write flag of the X instruction
//   wbsel_X_i                  X writeback select (2'b01 = load data)
//   taken_X_i                  X branch/jump resolved taken
//   lsreq_M_i                  M instruction accesses data memory
//   memack_i                   data memory completes the access this cycle
//   memreq_o                   access request to data memory
//   pcen_o, en_*_o             PC and stage register load enables
//   flush_*_o                  load a bubble into the stage register
//   timeout_o                  sticky memory-timeout error (ERR state)
//   stallcnt_o, flushcnt_o     saturating performance counters
//
// Build option
//   PIPE_PERF_CNT_EN  when defined, stallcnt_o counts cycles with pcen_o=0 and
//                     flushcnt_o counts branch flushes. When undefined, both
//                     outputs are tied to zero and no counter flops exist.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  rs1addr_D_i,
    input  logic [4:0]  rs2addr_D_i,
    input  logic        rs1use_D_i,
    input  logic        rs2use_D_i,
    input  logic [4:0]  rdaddr_X_i,
    input  logic        rdwr_X_i,
    input  logic [1:0]  wbsel_X_i,
    input  logic        taken_X_i,
    input  logic        lsreq_M_i,
    input  logic        memack_i,
    output logic        memreq_o,
    output logic        pcen_o,
    output logic        en_FD_o,
    output logic        en_DX_o,
    output logic        en_XM_o,
    output logic        en_MW_o,
    output logic        flush_FD_o,
    output logic        flush_DX_o,
    output logic        flush_MW_o,
    output logic        timeout_o,
    output logic [31:0] stallcnt_o,
    output logic [31:0] flushcnt_o
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MEMWAIT = 2'b01,
        ST_ERR     = 2'b10
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_wcnt;
    logic [7:0] w_wcnt_nxt;
    logic       w_load_use;
    logic       w_mem_hold;
    logic       w_branch_flush;

    // Load in X whose result is needed by D; x0 never creates a dependency.
    assign w_load_use = rdwr_X_i && (wbsel_X_i == 2'b01) && (rdaddr_X_i != 5'd0) &&
                        ((rs1use_D_i && (rs1addr_D_i == rdaddr_X_i)) ||
                         (rs2use_D_i && (rs2addr_D_i == rdaddr_X_i)));

    // Front of the pipe is held while an M access is pending; an ack in the
    // same cycle releases immediately, both from RUN and from MEMWAIT.
    assign w_mem_hold = ((r_state == ST_RUN) && lsreq_M_i && !memack_i) ||
                        ((r_state == ST_MEMWAIT) && !memack_i);

    // State and wait-counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_RUN;
            r_wcnt  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    // Next-state and wait-count logic.
    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        case (r_state)
            ST_RUN: begin
                if (lsreq_M_i && !memack_i) begin
                    w_state_nxt = ST_MEMWAIT;
                    w_wcnt_nxt  = 8'd1;
                end else begin
                    w_state_nxt = ST_RUN;
                    w_wcnt_nxt  = 8'd0;
                end
            end
            ST_MEMWAIT: begin
                if (memack_i) begin
                    w_state_nxt = ST_RUN;
                    w_wcnt_nxt  = 8'd0;
                end else if (r_wcnt == TIMEOUT_LIM) begin
                    w_state_nxt = ST_ERR;
                    w_wcnt_nxt  = r_wcnt;
                end else begin
                    w_state_nxt = ST_MEMWAIT;
                    w_wcnt_nxt  = r_wcnt + 8'd1;
                end
            end
            ST_ERR: begin
                // Only reset leaves ERR; late acks are ignored.
                w_state_nxt = ST_ERR;
                w_wcnt_nxt  = r_wcnt;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_wcnt_nxt  = 8'd0;
            end
        endcase
    end

    // Stage enables, flush strobes, memory request and error flag.
    always_comb begin
        pcen_o         = 1'b1;
        en_FD_o        = 1'b1;
        en_DX_o        = 1'b1;
        en_XM_o        = 1'b1;
        en_MW_o        = 1'b1;
        flush_FD_o     = 1'b0;
        flush_DX_o     = 1'b0;
        flush_MW_o     = 1'b0;
        memreq_o       = 1'b0;
        timeout_o      = 1'b0;
        w_branch_flush = 1'b0;

        if (rst_i) begin
            pcen_o     = 1'b0;
            en_FD_o    = 1'b0;
            en_DX_o    = 1'b0;
            en_XM_o    = 1'b0;
            en_MW_o    = 1'b0;
            flush_FD_o = 1'b1;
            flush_DX_o = 1'b1;
            flush_MW_o = 1'b1;
        end else if ((r_state != ST_RUN) && (r_state != ST_MEMWAIT)) begin
            // ERR (and any illegal encoding): freeze the pipe, bubble M/W.
            pcen_o     = 1'b0;
            en_FD_o    = 1'b0;
            en_DX_o    = 1'b0;
            en_XM_o    = 1'b0;
            en_MW_o    = 1'b0;
            flush_MW_o = 1'b1;
            timeout_o  = (r_state == ST_ERR);
        end else begin
            // The request stays up for the whole wait, including the ack cycle.
            memreq_o = (r_state == ST_MEMWAIT) || lsreq_M_i;
            if (w_mem_hold) begin
                pcen_o     = 1'b0;
                en_FD_o    = 1'b0;
                en_DX_o    = 1'b0;
                en_XM_o    = 1'b0;
                flush_MW_o = 1'b1;
            end else if (taken_X_i) begin
                // D holds a wrong-path instruction, so a load-use match is moot.
                flush_FD_o     = 1'b1;
                flush_DX_o     = 1'b1;
                w_branch_flush = 1'b1;
            end else if (w_load_use) begin
                pcen_o     = 1'b0;
                en_FD_o    = 1'b0;
                flush_DX_o = 1'b1;
            end else begin
                pcen_o = 1'b1;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_stallcnt;
    logic [31:0] r_flushcnt;

    // Saturating stall and branch-flush counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stallcnt <= 32'd0;
            r_flushcnt <= 32'd0;
        end else begin
            if (!pcen_o && (r_stallcnt != 32'hFFFF_FFFF)) begin
                r_stallcnt <= r_stallcnt + 32'd1;
            end else begin
                r_stallcnt <= r_stallcnt;
            end
            if (w_branch_flush && (r_flushcnt != 32'hFFFF_FFFF)) begin
                r_flushcnt <= r_flushcnt + 32'd1;
            end else begin
                r_flushcnt <= r_flushcnt;
            end
        end
    end

    assign stallcnt_o = r_stallcnt;
    assign flushcnt_o = r_flushcnt;
`else
    assign stallcnt_o = 32'd0;
    assign flushcnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed, table-driven bench for pipe_hazard_ctrl (TIMEOUT_CYC = 4).
//   Each vector holds the inputs for one cycle and the expected combinational
//   outputs packed as {memreq, pcen, en_FD, en_DX, en_XM, en_MW,
//   flush_FD, flush_DX, flush_MW} plus the expected timeout flag. Inputs are
//   driven at the falling edge and outputs sampled 2 time units later. The
//   expected performance counters are accumulated from the expected outputs.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rdwr;
        logic [1:0] wbsel;
        logic       taken;
        logic       lsreq;
        logic       ack;
        logic [8:0] exp;
        logic       exp_to;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1addr, rs2addr, rdaddr;
    logic        rs1use, rs2use, rdwr, taken, lsreq, memack;
    logic [1:0]  wbsel;
    logic        memreq, pcen, en_fd, en_dx, en_xm, en_mw;
    logic        flush_fd, flush_dx, flush_mw, timeout;
    logic [31:0] stallcnt, flushcnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_stall = 32'd0;
    logic [31:0] exp_flush = 32'd0;

    pipe_hazard_ctrl #(.TIMEOUT_CYC(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rs1addr_D_i (rs1addr),
        .rs2addr_D_i (rs2addr),
        .rs1use_D_i  (rs1use),
        .rs2use_D_i  (rs2use),
        .rdaddr_X_i  (rdaddr),
        .rdwr_X_i    (rdwr),
        .wbsel_X_i   (wbsel),
        .taken_X_i   (taken),
        .lsreq_M_i   (lsreq),
        .memack_i    (memack),
        .memreq_o    (memreq),
        .pcen_o      (pcen),
        .en_FD_o     (en_fd),
        .en_DX_o     (en_dx),
        .en_XM_o     (en_xm),
        .en_MW_o     (en_mw),
        .flush_FD_o  (flush_fd),
        .flush_DX_o  (flush_dx),
        .flush_MW_o  (flush_mw),
        .timeout_o   (timeout),
        .stallcnt_o  (stallcnt),
        .flushcnt_o  (flushcnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                                input logic x1, input logic x2, input logic [4:0] d,
                                input logic w, input logic [1:0] sel, input logic t,
                                input logic lq, input logic ak, input logic [8:0] e,
                                input logic eto);
        vec_t v;
        v.rst = r; v.rs1 = a1; v.rs2 = a2; v.u1 = x1; v.u2 = x2; v.rd = d;
        v.rdwr = w; v.wbsel = sel; v.taken = t; v.lsreq = lq; v.ack = ak;
        v.exp = e; v.exp_to = eto;
        return v;
    endfunction

    task automatic step(input vec_t v, input string name);
        logic [8:0]  act;
        logic [31:0] es;
        logic [31:0] ef;
        @(negedge clk);
        rst = v.rst; rs1addr = v.rs1; rs2addr = v.rs2; rs1use = v.u1; rs2use = v.u2;
        rdaddr = v.rd; rdwr = v.rdwr; wbsel = v.wbsel; taken = v.taken;
        lsreq = v.lsreq; memack = v.ack;
        if (v.rst) begin
            exp_stall = 32'd0;
            exp_flush = 32'd0;
        end
        #2;
        act = {memreq, pcen, en_fd, en_dx, en_xm, en_mw, flush_fd, flush_dx, flush_mw};
        checks++;
        if (act !== v.exp) begin
            errors++;
            $display("FAIL %s outputs got %b want %b", name, act, v.exp);
        end
        checks++;
        if (timeout !== v.exp_to) begin
            errors++;
            $display("FAIL %s timeout got %b want %b", name, timeout, v.exp_to);
        end
        es = PERF ? exp_stall : 32'd0;
        ef = PERF ? exp_flush : 32'd0;
        checks++;
        if ((stallcnt !== es) || (flushcnt !== ef)) begin
            errors++;
            $display("FAIL %s counters got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     name, stallcnt, flushcnt, es, ef);
        end
        if (!v.rst) begin
            if (!v.exp[7]) exp_stall = exp_stall + 32'd1;
            if (v.exp[2])  exp_flush = exp_flush + 32'd1;
        end
    endtask

    localparam logic [8:0] E_IDLE  = 9'b0_11111_000;
    localparam logic [8:0] E_REQ   = 9'b1_11111_000;
    localparam logic [8:0] E_LU    = 9'b0_00111_010;
    localparam logic [8:0] E_BR    = 9'b0_11111_110;
    localparam logic [8:0] E_MEM   = 9'b1_00001_001;
    localparam logic [8:0] E_RST   = 9'b0_00000_111;
    localparam logic [8:0] E_ERR   = 9'b0_00000_001;

    vec_t tbl [12];

    initial begin
        rst = 1'b1; rs1addr = 5'd0; rs2addr = 5'd0; rs1use = 1'b0; rs2use = 1'b0;
        rdaddr = 5'd0; rdwr = 1'b0; wbsel = 2'b00; taken = 1'b0; lsreq = 1'b0;
        memack = 1'b0;

        //            rst rs1    rs2    u1    u2    rd     wr    wbsel  tk    lsq   ack   exp     to
        tbl[0]  = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, E_IDLE, 1'b0);
        tbl[1]  = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, E_REQ,  1'b0);
        tbl[2]  = mk(1'b0, 5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, E_LU,   1'b0);
        tbl[3]  = mk(1'b0, 5'd3, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, E_IDLE, 1'b0);
        tbl[4]  = mk(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, E_IDLE, 1'b0);
        tbl[5]  = mk(1'b0, 5'd9, 5'd1, 1'b1, 1'b0, 5'd9, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, E_LU,   1'b0);
        tbl[6]  = mk(1'b0, 5'd9, 5'd1, 1'b0, 1'b1, 5'd9, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, E_IDLE, 1'b0);
        tbl[7]  = mk(1'b0, 5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, E_IDLE, 1'b0);
        tbl[8]  = mk(1'b0, 5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, E_IDLE, 1'b0);
        tbl[9]  = mk(1'b0, 5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, E_BR,   1'b0);
        tbl[10] = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, E_IDLE, 1'b0);
        tbl[11] = mk(1'b0, 5'd4, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, E_IDLE, 1'b0);

        step(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, E_RST, 1'b0), "reset");

        for (int i = 0; i < 12; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Memory stall, ack three cycles after the request cycle.
        step(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, E_MEM,  1'b0), "mem_req");
        step(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, E_MEM,  1'b0), "mem_w1");
        step(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, E_MEM,  1'b0), "mem_w2");
        step(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, E_REQ,  1'b0), "mem_ack");
        step(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, E_IDLE, 1'b0), "mem_after");

        // Release from MEMWAIT applies load-use on the held X/D contents.
        step(mk(1'b0, 5'd6, 5'd2, 1'b1, 1'b0, 5'd6, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, E_MEM,  1'b0), "lu_hold");
        step(mk(1'b0, 5'd6, 5'd2, 1'b1, 1'b0, 5'd6, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 9'b1_00111_010, 1'b0), "lu_release");
        step(mk(1'b0, 5'd6, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, E_IDLE, 1'b0), "lu_reeval");

        // Memory stall outranks a branch; branch flushes on release.
        step(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, E_MEM,  1'b0), "br_hold");
        step(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 9'b1_11111_110, 1'b0), "br_release");

        // Reset in the middle of a wait returns to RUN.
        step(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, E_MEM,  1'b0), "rw_req");
        step(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, E_MEM,  1'b0), "rw_w1");
        step(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, E_MEM,  1'b0), "rw_w2");
        step(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, E_RST,  1'b0), "rw_reset");
        step(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, E_IDLE, 1'b0), "rw_run");

        // Timeout: four MEMWAIT cycles with no ack, then sticky ERR.
        step(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, E_MEM,  1'b0), "to_req");
        for (int i = 1; i <= 4; i++) begin
            step(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, E_MEM, 1'b0),
                 $sformatf("to_w%0d", i));
        end
        step(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, E_ERR,  1'b1), "to_err1");
        step(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, E_ERR,  1'b1), "to_err2");
        step(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, E_RST,  1'b0), "to_reset");
        step(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, E_IDLE, 1'b0), "to_run");
        step(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, E_BR,   1'b0), "to_branch");
        step(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, E_IDLE, 1'b0), "final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
